// File: rtl/tcp_rx_msg_noc_if_out_mc_pkg.sv
// tcp_rx_msg_noc_if_out_mc_pkg
//   Shared definitions for the multi-channel RX pointer-message NoC output
//   interface: field widths, the pointer-message type code, the flit layout
//   (packed struct, MSB first) and a helper that formats one flit.
//   No ports.
package tcp_rx_msg_noc_if_out_mc_pkg;

    localparam int XY_WIDTH         = 8;
    localparam int NOC_FBITS_WIDTH  = 4;
    localparam int NOC_DATA_WIDTH   = 128;
    localparam int FLOWID_W         = 8;
    localparam int RX_PAYLOAD_PTR_W = 16;
    localparam int HEAD_PTR_W       = RX_PAYLOAD_PTR_W + 1;   // pointer plus wrap bit
    localparam int MSG_LEN_W        = 8;
    localparam int MSG_TYPE_W       = 8;
    localparam int CNT_W            = 16;

    localparam logic [MSG_TYPE_W-1:0] TCP_RX_MSG_PTR = 8'h09;

    localparam int FLIT_USED_W = 4 * XY_WIDTH + NOC_FBITS_WIDTH + MSG_LEN_W + MSG_TYPE_W
                               + FLOWID_W + HEAD_PTR_W + RX_PAYLOAD_PTR_W;
    localparam int FLIT_PAD_W  = NOC_DATA_WIDTH - FLIT_USED_W;

    // LSB offset of each field inside the flit
    localparam int LEN_LSB      = FLIT_PAD_W;
    localparam int HEAD_PTR_LSB = LEN_LSB + RX_PAYLOAD_PTR_W;
    localparam int FLOWID_LSB   = HEAD_PTR_LSB + HEAD_PTR_W;
    localparam int SRC_Y_LSB    = FLOWID_LSB + FLOWID_W;
    localparam int SRC_X_LSB    = SRC_Y_LSB + XY_WIDTH;
    localparam int MSG_TYPE_LSB = SRC_X_LSB + XY_WIDTH;
    localparam int MSG_LEN_LSB  = MSG_TYPE_LSB + MSG_TYPE_W;
    localparam int FBITS_LSB    = MSG_LEN_LSB + MSG_LEN_W;
    localparam int DST_Y_LSB    = FBITS_LSB + NOC_FBITS_WIDTH;
    localparam int DST_X_LSB    = DST_Y_LSB + XY_WIDTH;

    typedef struct packed {
        logic [XY_WIDTH-1:0]         dst_x;
        logic [XY_WIDTH-1:0]         dst_y;
        logic [NOC_FBITS_WIDTH-1:0]  dst_fbits;
        logic [MSG_LEN_W-1:0]        msg_len;
        logic [MSG_TYPE_W-1:0]       msg_type;
        logic [XY_WIDTH-1:0]         src_x;
        logic [XY_WIDTH-1:0]         src_y;
        logic [FLOWID_W-1:0]         flowid;
        logic [HEAD_PTR_W-1:0]       head_ptr;
        logic [RX_PAYLOAD_PTR_W-1:0] len;
        logic [FLIT_PAD_W-1:0]       pad;
    } ptr_flit_t;

    function automatic ptr_flit_t build_ptr_flit(
        input logic [XY_WIDTH-1:0]         dst_x,
        input logic [XY_WIDTH-1:0]         dst_y,
        input logic [NOC_FBITS_WIDTH-1:0]  dst_fbits,
        input logic [XY_WIDTH-1:0]         src_x,
        input logic [XY_WIDTH-1:0]         src_y,
        input logic [FLOWID_W-1:0]         flowid,
        input logic [HEAD_PTR_W-1:0]       head_ptr,
        input logic [RX_PAYLOAD_PTR_W-1:0] len
    );
        ptr_flit_t f;
        f.dst_x     = dst_x;
        f.dst_y     = dst_y;
        f.dst_fbits = dst_fbits;
        f.msg_len   = '0;          // pointer message is header-only
        f.msg_type  = TCP_RX_MSG_PTR;
        f.src_x     = src_x;
        f.src_y     = src_y;
        f.flowid    = flowid;
        f.head_ptr  = head_ptr;
        f.len       = len;
        f.pad       = '0;
        return f;
    endfunction

endpackage

// File: rtl/tcp_rx_msg_noc_if_out_mc_if.sv
// tcp_rx_msg_noc_if_out_mc_if
//   Single-flit valid/ready channel toward the tile's NoC output router port.
//   Ports (signals):
//     tcp_rx_ptr_if_noc_val   flit valid (driven by master)
//     tcp_rx_ptr_if_noc_data  flit payload (driven by master)
//     noc_tcp_rx_ptr_if_rdy   router accepts flit (driven by slave)
interface tcp_rx_msg_noc_if_out_mc_if
    import tcp_rx_msg_noc_if_out_mc_pkg::*;
    ;

    logic                      tcp_rx_ptr_if_noc_val;
    logic [NOC_DATA_WIDTH-1:0] tcp_rx_ptr_if_noc_data;
    logic                      noc_tcp_rx_ptr_if_rdy;

    modport master (
        output tcp_rx_ptr_if_noc_val,
        output tcp_rx_ptr_if_noc_data,
        input  noc_tcp_rx_ptr_if_rdy
    );

    modport slave (
        input  tcp_rx_ptr_if_noc_val,
        input  tcp_rx_ptr_if_noc_data,
        output noc_tcp_rx_ptr_if_rdy
    );

endinterface

// File: rtl/tcp_rx_msg_noc_if_out_mc_rr_arbiter_mc.sv
// rr_arbiter_mc
//   Round-robin arbiter over NUM_CHAN requesters. Grants the first asserted
//   request at or after rr_ptr (cyclic); rr_ptr moves past the winner only
//   when the grant is actually consumed (advance).
//   Ports:
//     clk, rst   clock, synchronous active-high reset (rr_ptr -> 0)
//     req        per-channel request
//     advance    winner accepted this cycle
//     grant      one-hot grant (zero if no request)
//     grant_idx  index of the granted channel
//     grant_val  some channel is granted
module rr_arbiter_mc #(
    parameter  int NUM_CHAN = 2,
    localparam int IDX_W    = (NUM_CHAN > 1) ? $clog2(NUM_CHAN) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_CHAN-1:0] req,
    input  logic                advance,
    output logic [NUM_CHAN-1:0] grant,
    output logic [IDX_W-1:0]    grant_idx,
    output logic                grant_val
);

    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] next_ptr;

    always_comb begin
        logic [IDX_W:0]   sum;
        logic [IDX_W-1:0] idx;
        sum       = '0;
        idx       = '0;
        grant     = '0;
        grant_idx = '0;
        grant_val = 1'b0;
        for (int i = 0; i < NUM_CHAN; i++) begin
            // extra bit keeps the wrap compare correct for non-power-of-two NUM_CHAN
            sum = {1'b0, rr_ptr} + (IDX_W + 1)'(i);
            if (sum >= (IDX_W + 1)'(NUM_CHAN))
                sum = sum - (IDX_W + 1)'(NUM_CHAN);
            idx = sum[IDX_W-1:0];
            if (!grant_val && req[idx]) begin
                grant_val  = 1'b1;
                grant_idx  = idx;
                grant[idx] = 1'b1;
            end
        end
    end

    // With one channel the compare is always true, pinning rr_ptr at 0.
    assign next_ptr = (grant_idx == IDX_W'(NUM_CHAN - 1)) ? '0 : grant_idx + 1'b1;

    always_ff @(posedge clk) begin
        if (rst)
            rr_ptr <= '0;
        else if (advance && grant_val)
            rr_ptr <= next_ptr;
    end

endmodule

// File: rtl/tcp_rx_msg_noc_if_out_mc.sv
// tcp_rx_msg_noc_if_out_mc
//   Collects message-ready notifications from NUM_CHAN RX poller channels,
//   arbitrates round-robin, formats the winner into a single pointer-message
//   flit and queues it in a DEPTH-entry FIFO toward the NoC router port.
//   Ports:
//     clk, rst                     clock, synchronous active-high reset
//     noc                          flit channel toward NoC (master modport)
//     poller_msg_noc_if_meta_val   per-channel request valid
//     poller_msg_noc_if_flowid     packed flow IDs, channel i at [i*FLOWID_W +: FLOWID_W]
//     poller_msg_noc_if_head_ptr   packed head pointers (with wrap bit)
//     poller_msg_noc_if_len        packed lengths
//     poller_msg_noc_if_dst_x/y    packed destination coordinates
//     poller_msg_noc_if_dst_fbits  packed destination fbits
//     noc_if_poller_msg_meta_rdy   per-channel accept, one-hot or zero
//     chan_msg_cnt                 per-channel wrapping count of accepted requests
module tcp_rx_msg_noc_if_out_mc
    import tcp_rx_msg_noc_if_out_mc_pkg::*;
#(
    parameter int SRC_X    = -1,
    parameter int SRC_Y    = -1,
    parameter int NUM_CHAN = 2,
    parameter int DEPTH    = 4
) (
    input  logic                                   clk,
    input  logic                                   rst,
    tcp_rx_msg_noc_if_out_mc_if.master             noc,
    input  logic [NUM_CHAN-1:0]                    poller_msg_noc_if_meta_val,
    input  logic [NUM_CHAN*FLOWID_W-1:0]           poller_msg_noc_if_flowid,
    input  logic [NUM_CHAN*HEAD_PTR_W-1:0]         poller_msg_noc_if_head_ptr,
    input  logic [NUM_CHAN*RX_PAYLOAD_PTR_W-1:0]   poller_msg_noc_if_len,
    input  logic [NUM_CHAN*XY_WIDTH-1:0]           poller_msg_noc_if_dst_x,
    input  logic [NUM_CHAN*XY_WIDTH-1:0]           poller_msg_noc_if_dst_y,
    input  logic [NUM_CHAN*NOC_FBITS_WIDTH-1:0]    poller_msg_noc_if_dst_fbits,
    output logic [NUM_CHAN-1:0]                    noc_if_poller_msg_meta_rdy,
    output logic [NUM_CHAN*CNT_W-1:0]              chan_msg_cnt
);

    localparam int IDX_W = (NUM_CHAN > 1) ? $clog2(NUM_CHAN) : 1;
    localparam int AW    = $clog2(DEPTH);

    localparam logic [XY_WIDTH-1:0] SRC_X_F = XY_WIDTH'(SRC_X);
    localparam logic [XY_WIDTH-1:0] SRC_Y_F = XY_WIDTH'(SRC_Y);

    logic [NUM_CHAN-1:0] grant;
    logic [IDX_W-1:0]    grant_idx;
    logic                grant_val;
    logic                space_ok;
    logic                push;
    logic                pop;
    logic                full;
    logic                empty;

    ptr_flit_t           chan_flit [NUM_CHAN];
    ptr_flit_t           fifo_mem  [DEPTH];
    logic [AW:0]         wr_ptr;
    logic [AW:0]         rd_ptr;
    logic [CNT_W-1:0]    cnt_q     [NUM_CHAN];

    rr_arbiter_mc #(
        .NUM_CHAN (NUM_CHAN)
    ) u_arb (
        .clk       (clk),
        .rst       (rst),
        .req       (poller_msg_noc_if_meta_val),
        .advance   (push),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_val (grant_val)
    );

    // Accept depends on "full" alone, never on a same-cycle pop, so the
    // ready path does not combinationally depend on the router's ready.
    assign space_ok                   = !full && !rst;
    assign noc_if_poller_msg_meta_rdy = grant & {NUM_CHAN{space_ok}};
    assign push                       = grant_val && space_ok;

    for (genvar c = 0; c < NUM_CHAN; c++) begin : g_chan
        assign chan_flit[c] = build_ptr_flit(
            poller_msg_noc_if_dst_x    [c*XY_WIDTH         +: XY_WIDTH],
            poller_msg_noc_if_dst_y    [c*XY_WIDTH         +: XY_WIDTH],
            poller_msg_noc_if_dst_fbits[c*NOC_FBITS_WIDTH  +: NOC_FBITS_WIDTH],
            SRC_X_F,
            SRC_Y_F,
            poller_msg_noc_if_flowid   [c*FLOWID_W         +: FLOWID_W],
            poller_msg_noc_if_head_ptr [c*HEAD_PTR_W       +: HEAD_PTR_W],
            poller_msg_noc_if_len      [c*RX_PAYLOAD_PTR_W +: RX_PAYLOAD_PTR_W]);
        assign chan_msg_cnt[c*CNT_W +: CNT_W] = cnt_q[c];
    end

    // Pointers carry one extra bit to tell full from empty.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop   = !empty && noc.noc_tcp_rx_ptr_if_rdy;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr[AW-1:0]] <= chan_flit[grant_idx];
                wr_ptr                   <= wr_ptr + 1'b1;
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < NUM_CHAN; c++)
                cnt_q[c] <= '0;
        end else if (push) begin
            cnt_q[grant_idx] <= cnt_q[grant_idx] + 1'b1;
        end
    end

    // Storage is not reset; gate the output so stale entries never show.
    assign noc.tcp_rx_ptr_if_noc_val  = !empty;
    assign noc.tcp_rx_ptr_if_noc_data = empty ? '0 : fifo_mem[rd_ptr[AW-1:0]];

endmodule

// File: tb/tb_tcp_rx_msg_noc_if_out_mc.sv
module tb_tcp_rx_msg_noc_if_out_mc;

    localparam int NC = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    tcp_rx_msg_noc_if_out_mc_if noc_bus ();

    logic [NC-1:0]    meta_val;
    logic [NC-1:0]    meta_rdy;
    logic [NC*16-1:0] cnt;

    logic [7:0]  fid [NC];
    logic [16:0] hp  [NC];
    logic [15:0] ln  [NC];
    logic [7:0]  dx  [NC];
    logic [7:0]  dy  [NC];
    logic [3:0]  fb  [NC];

    logic [NC*8-1:0]  fid_p;
    logic [NC*17-1:0] hp_p;
    logic [NC*16-1:0] ln_p;
    logic [NC*8-1:0]  dx_p;
    logic [NC*8-1:0]  dy_p;
    logic [NC*4-1:0]  fb_p;

    always_comb begin
        fid_p = '0; hp_p = '0; ln_p = '0; dx_p = '0; dy_p = '0; fb_p = '0;
        for (int c = 0; c < NC; c++) begin
            fid_p[c*8 +: 8]   = fid[c];
            hp_p[c*17 +: 17]  = hp[c];
            ln_p[c*16 +: 16]  = ln[c];
            dx_p[c*8 +: 8]    = dx[c];
            dy_p[c*8 +: 8]    = dy[c];
            fb_p[c*4 +: 4]    = fb[c];
        end
    end

    tcp_rx_msg_noc_if_out_mc #(
        .SRC_X    (3),
        .SRC_Y    (7),
        .NUM_CHAN (NC),
        .DEPTH    (4)
    ) dut (
        .clk                         (clk),
        .rst                         (rst),
        .noc                         (noc_bus),
        .poller_msg_noc_if_meta_val  (meta_val),
        .poller_msg_noc_if_flowid    (fid_p),
        .poller_msg_noc_if_head_ptr  (hp_p),
        .poller_msg_noc_if_len       (ln_p),
        .poller_msg_noc_if_dst_x     (dx_p),
        .poller_msg_noc_if_dst_y     (dy_p),
        .poller_msg_noc_if_dst_fbits (fb_p),
        .noc_if_poller_msg_meta_rdy  (meta_rdy),
        .chan_msg_cnt                (cnt)
    );

    int nvec = 0;
    int nerr = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Flit layout, MSB first: dst_x, dst_y, fbits, msg_len=0, type=0x09,
    // src_x=3, src_y=7, flowid, head_ptr(17), len(16), 35 zero bits.
    function automatic logic [127:0] flit_of(input logic [7:0] x, input logic [7:0] y,
                                             input logic [3:0] f, input logic [7:0] id,
                                             input logic [16:0] h, input logic [15:0] l);
        return {x, y, f, 8'h00, 8'h09, 8'd3, 8'd7, id, h, l, 35'd0};
    endfunction

    function automatic logic [7:0] head_fid();
        return noc_bus.tcp_rx_ptr_if_noc_data[75:68];
    endfunction

    int exp_order [5] = '{0, 1, 2, 3, 0};

    initial begin
        noc_bus.noc_tcp_rx_ptr_if_rdy = 1'b0;
        meta_val = '0;
        for (int c = 0; c < NC; c++) begin
            fid[c] = '0; hp[c] = '0; ln[c] = '0; dx[c] = '0; dy[c] = '0; fb[c] = '0;
        end

        // reset: no accept during the reset cycle
        rst = 1'b1;
        meta_val = 4'b0001;
        #1;
        chk("rdy_in_reset", meta_rdy, 4'b0000);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        meta_val = '0;
        #1;
        chk("rst_val", noc_bus.tcp_rx_ptr_if_noc_val, 1'b0);
        chk("rst_data", noc_bus.tcp_rx_ptr_if_noc_data, 128'd0);
        chk("rst_cnt", cnt, 64'd0);

        // contention: all four channels valid, order 0,1,2,3,0
        noc_bus.noc_tcp_rx_ptr_if_rdy = 1'b1;
        for (int c = 0; c < NC; c++) fid[c] = 8'h10 + 8'(c);
        meta_val = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("cont_rdy", meta_rdy, 4'b0001 << exp_order[k]);
            @(posedge clk);
            #1;
            chk("cont_val", noc_bus.tcp_rx_ptr_if_noc_val, 1'b1);
            chk("cont_fid", head_fid(), 8'h10 + 8'(exp_order[k]));
        end
        meta_val = '0;
        chk("cont_cnt", cnt, {16'd1, 16'd1, 16'd1, 16'd2});
        @(posedge clk);
        #1;
        chk("cont_drain", noc_bus.tcp_rx_ptr_if_noc_val, 1'b0);

        // single request on ch0, flit visible the cycle after accept
        fid[0] = 8'd5; hp[0] = 17'h10040; ln[0] = 16'h0100;
        dx[0] = 8'd2; dy[0] = 8'd3; fb[0] = 4'd1;
        meta_val = 4'b0001;
        #1;
        chk("single_rdy", meta_rdy, 4'b0001);
        chk("single_pre_val", noc_bus.tcp_rx_ptr_if_noc_val, 1'b0);
        @(posedge clk);
        #1;
        meta_val = '0;
        chk("single_val", noc_bus.tcp_rx_ptr_if_noc_val, 1'b1);
        chk("single_flit", noc_bus.tcp_rx_ptr_if_noc_data,
            flit_of(8'd2, 8'd3, 4'd1, 8'd5, 17'h10040, 16'h0100));
        chk("single_cnt0", cnt[15:0], 16'd3);
        @(posedge clk);
        #1;
        chk("single_drain", noc_bus.tcp_rx_ptr_if_noc_val, 1'b0);

        // backpressure: four accepts fill the FIFO, then ready drops
        noc_bus.noc_tcp_rx_ptr_if_rdy = 1'b0;
        meta_val = 4'b0010;
        for (int n = 0; n < 4; n++) begin
            fid[1] = 8'h20 + 8'(n);
            #1;
            chk("bp_rdy", meta_rdy, 4'b0010);
            @(posedge clk);
            #1;
        end
        fid[1] = 8'h24;
        #1;
        chk("bp_full_rdy", meta_rdy, 4'b0000);
        chk("bp_head", head_fid(), 8'h20);
        @(posedge clk);
        #1;
        chk("bp_hold_rdy", meta_rdy, 4'b0000);
        chk("bp_hold_head", head_fid(), 8'h20);

        // full with pop in the same cycle: no push now, push next cycle
        noc_bus.noc_tcp_rx_ptr_if_rdy = 1'b1;
        #1;
        chk("fullpop_rdy", meta_rdy, 4'b0000);
        @(posedge clk);
        #1;
        chk("fullpop_head", head_fid(), 8'h21);
        chk("fullpop_rdy_next", meta_rdy, 4'b0010);
        @(posedge clk);
        #1;
        meta_val = '0;
        chk("bp_out2", head_fid(), 8'h22);
        @(posedge clk);
        #1;
        chk("bp_out3", head_fid(), 8'h23);
        @(posedge clk);
        #1;
        chk("bp_out4", head_fid(), 8'h24);
        chk("bp_val4", noc_bus.tcp_rx_ptr_if_noc_val, 1'b1);
        @(posedge clk);
        #1;
        chk("bp_empty", noc_bus.tcp_rx_ptr_if_noc_val, 1'b0);
        chk("bp_cnt1", cnt[31:16], 16'd6);

        // reset mid-stream: two queued flits discarded, rr_ptr back to 0
        noc_bus.noc_tcp_rx_ptr_if_rdy = 1'b0;
        fid[1] = 8'h30;
        meta_val = 4'b0010;
        @(posedge clk);
        #1;
        fid[1] = 8'h31;
        @(posedge clk);
        #1;
        meta_val = '0;
        chk("mid_val", noc_bus.tcp_rx_ptr_if_noc_val, 1'b1);
        chk("mid_head", head_fid(), 8'h30);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("mid_rst_val", noc_bus.tcp_rx_ptr_if_noc_val, 1'b0);
        chk("mid_rst_cnt", cnt, 64'd0);
        meta_val = 4'b1111;
        #1;
        chk("mid_rr0", meta_rdy, 4'b0001);
        meta_val = '0;
        noc_bus.noc_tcp_rx_ptr_if_rdy = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_no_stale1", noc_bus.tcp_rx_ptr_if_noc_val, 1'b0);
        @(posedge clk);
        #1;
        chk("mid_no_stale2", noc_bus.tcp_rx_ptr_if_noc_val, 1'b0);

        // counter wrap on ch2 after one ch0 accept
        fid[0] = 8'h40;
        meta_val = 4'b0001;
        @(posedge clk);
        #1;
        meta_val = '0;
        @(posedge clk);
        #1;
        chk("wrap_pre_val", noc_bus.tcp_rx_ptr_if_noc_val, 1'b0);
        meta_val = 4'b0100;
        repeat (65535) @(posedge clk);
        #1;
        chk("wrap_ffff", cnt[47:32], 16'hFFFF);
        @(posedge clk);
        #1;
        meta_val = '0;
        chk("wrap_cnt", cnt, {16'd0, 16'd0, 16'd0, 16'd1});
        @(posedge clk);
        #1;
        chk("wrap_drain", noc_bus.tcp_rx_ptr_if_noc_val, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
